// File: rtl/sr_flipflop.sv
// sr_flipflop
//   Bank of WIDTH independent clocked SR flip-flops sharing one clock and one
//   synchronous active-high reset. The S=R=1 case is resolved by BOTH_MODE
//   and is reported one cycle later on both_err.
//
// Parameters
//   WIDTH     : number of independent SR bits
//   RST_VAL   : value loaded into q on reset
//   BOTH_MODE : S=R=1 resolution (0 hold, 1 set, 2 clear, 3 toggle;
//               any other value holds)
//
// Ports
//   s        : per-bit set request
//   r        : per-bit reset request
//   clk      : rising-edge clock
//   q        : stored state (registered)
//   qbar     : bitwise complement of q (combinational)
//   rst      : synchronous active-high reset
//   both_err : registered per-bit flag, high for the cycle after s=r=1
module sr_flipflop #(
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RST_VAL   = '0,
  parameter int unsigned      BOTH_MODE = 0
) (
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clk,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  input  logic             rst,
  output logic [WIDTH-1:0] both_err
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] err_q;
  logic [WIDTH-1:0] err_d;

  // Next-state for each bit is resolved independently; bits never interact.
  always_comb begin
    q_d   = q_q;
    err_d = s & r;
    for (int i = 0; i < WIDTH; i++) begin
      unique case ({s[i], r[i]})
        2'b00: q_d[i] = q_q[i];
        2'b01: q_d[i] = 1'b0;
        2'b10: q_d[i] = 1'b1;
        2'b11: begin
          case (BOTH_MODE)
            1:       q_d[i] = 1'b1;
            2:       q_d[i] = 1'b0;
            3:       q_d[i] = ~q_q[i];
            default: q_d[i] = q_q[i];
          endcase
        end
        default: q_d[i] = q_q[i];
      endcase
    end
  end

  // No initial value: q stays unknown until the first reset or set/reset edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= RST_VAL;
      err_q <= '0;
    end else begin
      q_q   <= q_d;
      err_q <= err_d;
    end
  end

  assign q        = q_q;
  assign qbar     = ~q_q;
  assign both_err = err_q;

endmodule

// File: tb/tb_sr_flipflop.sv
module tb_sr_flipflop;

  logic clk = 1'b0;
  always #5 clk = ~clk;  // rising edges at 5, 15, 25, ...

  int checks = 0;
  int errors = 0;

  // Width-1 instances share stimulus; one per resolution mode plus an
  // out-of-range mode that must behave as hold.
  logic s1 = 1'b0, r1 = 1'b0, rst1 = 1'b0;
  logic [0:0] q_m0, qb_m0, e_m0;
  logic [0:0] q_m1, qb_m1, e_m1;
  logic [0:0] q_m2, qb_m2, e_m2;
  logic [0:0] q_m3, qb_m3, e_m3;
  logic [0:0] q_m7, qb_m7, e_m7;

  logic [3:0] s4 = 4'b0, r4 = 4'b0;
  logic       rst4 = 1'b0;
  logic [3:0] q_w4, qb_w4, e_w4;

  sr_flipflop #(.WIDTH(1), .RST_VAL(1'b0), .BOTH_MODE(0)) dut_m0 (
    .s(s1), .r(r1), .clk(clk), .q(q_m0), .qbar(qb_m0), .rst(rst1), .both_err(e_m0));
  sr_flipflop #(.WIDTH(1), .RST_VAL(1'b0), .BOTH_MODE(1)) dut_m1 (
    .s(s1), .r(r1), .clk(clk), .q(q_m1), .qbar(qb_m1), .rst(rst1), .both_err(e_m1));
  sr_flipflop #(.WIDTH(1), .RST_VAL(1'b0), .BOTH_MODE(2)) dut_m2 (
    .s(s1), .r(r1), .clk(clk), .q(q_m2), .qbar(qb_m2), .rst(rst1), .both_err(e_m2));
  sr_flipflop #(.WIDTH(1), .RST_VAL(1'b0), .BOTH_MODE(3)) dut_m3 (
    .s(s1), .r(r1), .clk(clk), .q(q_m3), .qbar(qb_m3), .rst(rst1), .both_err(e_m3));
  sr_flipflop #(.WIDTH(1), .RST_VAL(1'b0), .BOTH_MODE(7)) dut_m7 (
    .s(s1), .r(r1), .clk(clk), .q(q_m7), .qbar(qb_m7), .rst(rst1), .both_err(e_m7));
  sr_flipflop #(.WIDTH(4), .RST_VAL(4'b1010), .BOTH_MODE(0)) dut_w4 (
    .s(s4), .r(r4), .clk(clk), .q(q_w4), .qbar(qb_w4), .rst(rst4), .both_err(e_w4));

  // Drive width-1 inputs on the falling edge, then move to just after the
  // next rising edge for sampling.
  task automatic step1(input logic s_v, input logic r_v, input logic rst_v);
    @(negedge clk);
    s1 = s_v; r1 = r_v; rst1 = rst_v;
    @(posedge clk);
    #1;
  endtask

  task automatic step4(input logic [3:0] s_v, input logic [3:0] r_v, input logic rst_v);
    @(negedge clk);
    s4 = s_v; r4 = r_v; rst4 = rst_v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step1(1'b1, 1'b0, 1'b1);
    checks++;
    if ({q_m0, q_m1, q_m2, q_m3, q_m7} !== 5'b00000) begin
      errors++; $display("FAIL reset_q got %b exp 00000", {q_m0, q_m1, q_m2, q_m3, q_m7});
    end
    checks++;
    if ({qb_m0, e_m0} !== 2'b10) begin
      errors++; $display("FAIL reset_qbar_err got %b exp 10", {qb_m0, e_m0});
    end
  endtask

  task automatic test_basic();
    step1(1'b0, 1'b1, 1'b0);
    checks++;
    if ({q_m0, qb_m0, e_m0} !== 3'b010) begin
      errors++; $display("FAIL basic_r got %b exp 010", {q_m0, qb_m0, e_m0});
    end
    step1(1'b1, 1'b0, 1'b0);
    checks++;
    if ({q_m0, qb_m0, e_m0} !== 3'b100) begin
      errors++; $display("FAIL basic_s got %b exp 100", {q_m0, qb_m0, e_m0});
    end
    step1(1'b1, 1'b1, 1'b0);
    checks++;
    if ({q_m0, qb_m0, e_m0} !== 3'b101) begin
      errors++; $display("FAIL basic_both_hold got %b exp 101", {q_m0, qb_m0, e_m0});
    end
    step1(1'b0, 1'b0, 1'b0);
    checks++;
    if ({q_m0, e_m0} !== 2'b10) begin
      errors++; $display("FAIL basic_hold got %b exp 10", {q_m0, e_m0});
    end
  endtask

  task automatic test_sync_reset();
    step1(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    s1 = 1'b1; r1 = 1'b0; rst1 = 1'b1;
    #2;
    checks++;
    if (q_m0 !== 1'b1) begin
      errors++; $display("FAIL sreset_between_edges got %b exp 1", q_m0);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({q_m0, qb_m0} !== 2'b01) begin
      errors++; $display("FAIL sreset_priority got %b exp 01", {q_m0, qb_m0});
    end
    step1(1'b1, 1'b0, 1'b0);
    checks++;
    if (q_m0 !== 1'b1) begin
      errors++; $display("FAIL sreset_release got %b exp 1", q_m0);
    end
  endtask

  task automatic test_both_sweep();
    step1(1'b1, 1'b0, 1'b0);
    step1(1'b1, 1'b1, 1'b0);
    checks++;
    if ({q_m0, q_m1, q_m2, q_m3, q_m7} !== 5'b11001) begin
      errors++; $display("FAIL sweep_from1 got %b exp 11001", {q_m0, q_m1, q_m2, q_m3, q_m7});
    end
    step1(1'b0, 1'b1, 1'b0);
    step1(1'b1, 1'b1, 1'b0);
    checks++;
    if ({q_m0, q_m1, q_m2, q_m3, q_m7} !== 5'b01010) begin
      errors++; $display("FAIL sweep_from0 got %b exp 01010", {q_m0, q_m1, q_m2, q_m3, q_m7});
    end
    checks++;
    if ({qb_m0, qb_m1, qb_m2, qb_m3} !== 4'b1010) begin
      errors++; $display("FAIL sweep_qbar got %b exp 1010", {qb_m0, qb_m1, qb_m2, qb_m3});
    end
  endtask

  task automatic test_toggle();
    logic [3:0] exp_seq;
    exp_seq = 4'b1010;  // q after edges 1..4, MSB first
    step1(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step1(1'b1, 1'b1, 1'b0);
      checks++;
      if ({q_m3, e_m3} !== {exp_seq[3-k], 1'b1}) begin
        errors++; $display("FAIL toggle_%0d got %b exp %b", k, {q_m3, e_m3}, {exp_seq[3-k], 1'b1});
      end
    end
    step1(1'b0, 1'b0, 1'b0);
    checks++;
    if ({q_m3, e_m3} !== 2'b00) begin
      errors++; $display("FAIL toggle_release got %b exp 00", {q_m3, e_m3});
    end
  endtask

  task automatic test_width4();
    step4(4'b0000, 4'b0000, 1'b1);
    checks++;
    if ({q_w4, qb_w4, e_w4} !== 12'b1010_0101_0000) begin
      errors++; $display("FAIL w4_reset got %b exp 101001010000", {q_w4, qb_w4, e_w4});
    end
    step4(4'b0011, 4'b0100, 1'b0);
    checks++;
    if ({q_w4, e_w4} !== 8'b1011_0000) begin
      errors++; $display("FAIL w4_mixed got %b exp 10110000", {q_w4, e_w4});
    end
    step4(4'b1000, 4'b1000, 1'b0);
    checks++;
    if ({q_w4, e_w4} !== 8'b1011_1000) begin
      errors++; $display("FAIL w4_both got %b exp 10111000", {q_w4, e_w4});
    end
    step4(4'b0100, 4'b0011, 1'b0);
    checks++;
    if ({q_w4, qb_w4, e_w4} !== 12'b1100_0011_0000) begin
      errors++; $display("FAIL w4_swap got %b exp 110000110000", {q_w4, qb_w4, e_w4});
    end
  endtask

  task automatic test_glitch();
    step1(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    s1 = 1'b0; r1 = 1'b0;
    #1 s1 = 1'b1;
    #2 s1 = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({q_m0, q_m1, q_m2, q_m3} !== 4'b0000) begin
      errors++; $display("FAIL glitch got %b exp 0000", {q_m0, q_m1, q_m2, q_m3});
    end
  endtask

  initial begin
    #5000;
    errors++;
    $display("FAIL watchdog timeout got running exp finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_sync_reset();
    test_both_sweep();
    test_toggle();
    test_width4();
    test_glitch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_flipflop.md
# sr_flipflop

Clocked set/reset storage element, parameterised as a bank of WIDTH independent SR flip-flops sharing one clock and one reset. Each bit updates only on the rising clock edge. A parameter selects the resolution of the S=R=1 condition, and a registered flag reports that condition per bit. The block is used wherever latched event/clear status bits are needed, and as a width-1 standalone SR flip-flop.

## Interface
Parameters:
- WIDTH, 1, number of independent SR bits.
- RST_VAL, 0 (all bits), WIDTH-bit value loaded into q on reset.
- BOTH_MODE, 0, S=R=1 resolution per bit: 0 = hold, 1 = set-dominant, 2 = reset-dominant, 3 = toggle.

Ports (positional order is s, r, clk, q, qbar, rst, both_err):
- clk  input  1  rising-edge clock; one clock; all state updates on its rising edge.
- rst  input  1  reset; synchronous, active-high. When left unconnected or low, no reset occurs.
- s  input  WIDTH  per-bit set request.
- r  input  WIDTH  per-bit reset request.
- q  output  WIDTH  stored state, registered.
- qbar  output  WIDTH  always the bitwise complement of q, never independently registered.
- both_err  output  WIDTH  registered flag; bit i is high for the cycle after an edge that sampled s[i]=r[i]=1.

## Operation
- At each rising clk edge with rst=1: q <= RST_VAL, both_err <= 0. s and r are ignored.
- At each rising clk edge with rst=0, each bit i is evaluated independently:
  - s=0, r=0: q[i] holds.
  - s=0, r=1: q[i] <= 0.
  - s=1, r=0: q[i] <= 1.
  - s=1, r=1: resolved per BOTH_MODE. Mode 0 holds, mode 1 sets to 1, mode 2 clears to 0, mode 3 inverts.
- both_err[i] <= s[i] & r[i] on every non-reset edge, independent of BOTH_MODE.
- qbar = ~q combinationally at all times. q and qbar are never equal once q is known.
- Before the first reset or first set/reset edge, q is undefined (X in simulation). It must not be forced by an initial block.
- BOTH_MODE values other than 0–3 behave as mode 0.
- There is no asynchronous path. Changes on s and r between edges have no effect on q.

## Timing
- Latency: one clock. Inputs sampled at edge n appear on q/qbar/both_err just after edge n.
- Reset has priority over s and r at the same edge.
- Reset asserted mid-operation takes effect at the next rising edge only. Deasserting reset allows normal update at the following edge.
- Bits do not interact: any mix of set, reset, hold and both on different bits resolves correctly at the same edge.
- Inputs must be stable around the rising edge. Under the standard bench, inputs change on falling-phase boundaries and edges occur at 5, 15, 25, 35 ns.

## Test plan
- WIDTH=1, BOTH_MODE=0, rst unconnected, clk period 10 ns with the first rising edge at 5 ns, (s,r) = 00, 01, 10, 11 each for 10 ns. Required q: X after 5 ns, 0 after 15 ns, 1 after 25 ns, 1 (hold) after 35 ns. qbar is always ~q. both_err goes to 1 after 35 ns.
- Synchronous reset: q=1, assert rst with s=1 for one edge. Required: q=RST_VAL=0 and qbar=1 after that edge. Raising rst between edges must not change q before the next edge.
- BOTH_MODE sweep with WIDTH=1, starting from q=1 then from q=0, applying s=r=1 for one edge. Required result for q=1 / q=0: mode 0 gives 1 / 0, mode 1 gives 1 / 1, mode 2 gives 0 / 0, mode 3 gives 0 / 1.
- Mode 3 toggle: hold s=r=1 for 4 edges starting from q=0. Required q sequence: 1, 0, 1, 0. both_err stays 1 throughout, then falls to 0 one edge after s=r=0.
- WIDTH=4, RST_VAL=4'b1010: after reset q=1010. Then s=0011, r=0100 for one edge gives q=1011. Then s=1000, r=1000, mode 0, gives q=1011 and both_err=1000.
- Glitch immunity: pulse s high for 2 ns entirely between rising edges. Required: q unchanged.
